cim_host_sequencer: RTL and testbench

Host-side command sequencer directly upstream of the CIM processor top. It drives the core's operation code, 12-bit address and 32-bit data ports.
- Turns host commands plus a write-data stream into serial memory-load sequences: GAM, GWM and GIM.
- Runs the PIP pipeline for a programmed number of cycles.
- Reads activation memory back with RGA and forwards the core's out_valid/Q words to the host as a read stream.

---
 rtl/cim_host_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_cim_host_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_host_sequencer.sv
// Host-side command sequencer for the CIM core: streams memory loads,
// runs the PIP pipeline for a cycle count, and reads activation memory back.
module cim_host_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        core_state,
    output logic [ADDR_W-1:0] core_A,
    output logic [DATA_W-1:0] core_D,
    input  logic              core_out_valid,
    input  logic [DATA_W-1:0] core_Q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_GAM = 3'd1;
    localparam logic [2:0] OP_GWM = 3'd2;
    localparam logic [2:0] OP_GIM = 3'd3;
    localparam logic [2:0] OP_PIP = 3'd6;
    localparam logic [2:0] OP_RGA = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_ret;
    logic              r_illegal;

    logic              w_cmd_take;
    logic              w_cmd_bad;
    logic              w_wr_take;
    logic              w_ret_path;
    logic              w_ret_take;
    logic              w_last;
    logic [2:0]        w_load_code;

    logic [2:0]        w_core_state;
    logic [ADDR_W-1:0] w_core_A;
    logic [DATA_W-1:0] w_core_D;
    logic              w_rd_valid;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_done;
    logic              w_err;

    assign cmd_ready  = (r_state == S_IDLE);
    assign wr_ready   = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign w_cmd_take = cmd_ready && cmd_valid;
    assign w_cmd_bad  = (cmd_op > 3'd4);
    assign w_wr_take  = wr_ready && wr_valid;
    assign w_last     = (r_rem == LEN_W'(1));
    // Words beyond the requested count are dropped on the floor.
    assign w_ret_path = (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_ret_take = w_ret_path && core_out_valid && (r_ret != r_len);
    assign w_load_code = (r_op == 3'd0) ? OP_GAM :
                         (r_op == 3'd1) ? OP_GWM : OP_GIM;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_take) begin
                    if (w_cmd_bad || cmd_len == '0) w_state_nxt = S_DONE;
                    else if (cmd_op == 3'd3)        w_state_nxt = S_RUN;
                    else if (cmd_op == 3'd4)        w_state_nxt = S_READ;
                    else                            w_state_nxt = S_LOAD;
                end
            end
            S_LOAD:  if (w_wr_take && w_last) w_state_nxt = S_DONE;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_READ:  if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_ret == r_len) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch plus address, remaining and returned-word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_addr_cnt <= '0;
            r_rem      <= '0;
            r_len      <= '0;
            r_ret      <= '0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_cmd_take) begin
                r_op       <= cmd_op;
                r_addr_cnt <= cmd_addr;
                r_rem      <= cmd_len;
                r_len      <= cmd_len;
                r_ret      <= '0;
                r_illegal  <= w_cmd_bad;
            end
            if (w_wr_take || r_state == S_READ) begin
                r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
            end
            if (w_wr_take || r_state == S_RUN || r_state == S_READ) begin
                r_rem <= r_rem - LEN_W'(1);
            end
            if (w_ret_take) begin
                r_ret <= r_ret + LEN_W'(1);
            end
        end
    end

    // Next values of the registered core, read-back and status outputs
    always_comb begin
        w_core_state = OP_NOP;
        w_core_A     = core_A;
        w_core_D     = core_D;
        w_rd_valid   = 1'b0;
        w_rd_data    = rd_data;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (wr_valid) begin
                    w_core_state = w_load_code;
                    w_core_A     = r_addr_cnt;
                    w_core_D     = wr_data;
                end
            end
            S_RUN: begin
                w_core_state = OP_PIP;
                w_core_A     = '0;
                w_core_D     = '0;
            end
            S_READ: begin
                w_core_state = OP_RGA;
                w_core_A     = r_addr_cnt;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_err  = r_illegal;
            end
            default: ;
        endcase
        if (w_ret_path) begin
            w_rd_valid = w_ret_take;
            w_rd_data  = core_Q;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            core_state <= OP_NOP;
            core_A     <= '0;
            core_D     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            core_state <= w_core_state;
            core_A     <= w_core_A;
            core_D     <= w_core_D;
            rd_valid   <= w_rd_valid;
            rd_data    <= w_rd_data;
            done       <= w_done;
            err        <= w_err;
        end
    end

endmodule

// File: tb/tb_cim_host_sequencer.sv
// Testbench for cim_host_sequencer: command table plus scoreboard of
// expected core writes, read-back words and done/err pulses.
module tb_cim_host_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [11:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [2:0]  core_state;
    logic [11:0] core_A;
    logic [31:0] core_D;
    logic        core_out_valid = 1'b0;
    logic [31:0] core_Q = '0;
    logic        busy;
    logic        done;
    logic        err;

    cim_host_sequencer #(.ADDR_W(12), .DATA_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .core_state(core_state), .core_A(core_A), .core_D(core_D),
        .core_out_valid(core_out_valid), .core_Q(core_Q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] a;
        logic [31:0] d;
        logic        dm;
    } core_t;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [15:0] len;
        logic [31:0] seed;
        logic        exp_err;
    } vec_t;

    core_t       exp_core[$];
    logic [31:0] exp_rd[$];
    logic        exp_done[$];
    int          rga_t[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    vec_t        vecs[10];

    // Core stand-in: answers each RGA one cycle later with Q = A
    always @(posedge clk) begin
        cyc <= cyc + 1;
        core_out_valid <= (core_state == 3'd7);
        core_Q <= {20'd0, core_A};
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (core_state != 3'd0) begin
                if (exp_core.size() == 0) begin
                    chk("core_extra", {29'd0, core_state}, 32'd0);
                end else begin
                    core_t e;
                    e = exp_core.pop_front();
                    chk("core_state", {29'd0, core_state}, {29'd0, e.st});
                    chk("core_A", {20'd0, core_A}, {20'd0, e.a});
                    if (!e.dm) chk("core_D", core_D, e.d);
                end
                if (core_state == 3'd7) rga_t.push_back(cyc);
            end
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("rd_extra", {31'd0, rd_valid}, 32'd0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
                if (rga_t.size() != 0) chk("rd_latency", cyc - rga_t.pop_front(), 2);
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_extra", {31'd0, done}, 32'd0);
                else chk("err", {31'd0, err}, {31'd0, exp_done.pop_front()});
            end else if (err) begin
                chk("err_without_done", {31'd0, err}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [11:0] a,
                         input logic [15:0] n);
        int k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = a;
        cmd_len = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic push_core(input logic [2:0] st, input logic [11:0] a,
                             input logic [31:0] d, input logic dm);
        core_t e;
        e.st = st;
        e.a = a;
        e.d = d;
        e.dm = dm;
        exp_core.push_back(e);
    endtask

    task automatic run_cmd(input vec_t v);
        bit legal;
        logic [11:0] a;
        legal = (v.op <= 3'd4);
        if (legal && v.len != 0) begin
            for (int i = 0; i < int'(v.len); i++) begin
                a = v.addr + 12'(i);
                if (v.op <= 3'd2) push_core(v.op + 3'd1, a, v.seed + i, 1'b0);
                else if (v.op == 3'd3) push_core(3'd6, 12'd0, 32'd0, 1'b0);
                else begin
                    push_core(3'd7, a, 32'd0, 1'b1);
                    exp_rd.push_back({20'd0, a});
                end
            end
        end
        exp_done.push_back(v.exp_err);
        issue(v.op, v.addr, v.len);
        if (legal && v.op <= 3'd2 && v.len != 0) begin
            for (int i = 0; i < int'(v.len); i++) begin
                wr_valid = 1'b1;
                wr_data = v.seed + i;
                @(negedge clk);
            end
        end
        wr_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npip;
        int run;
        int maxrun;
        int ndone;
        int ncore;

        vecs[0] = '{3'd0, 12'h100, 16'd4, 32'hA000_0000, 1'b0};
        vecs[1] = '{3'd2, 12'hFFF, 16'd2, 32'h0000_BEE0, 1'b0};
        vecs[2] = '{3'd4, 12'h020, 16'd4, 32'd0, 1'b0};
        vecs[3] = '{3'd4, 12'h7FE, 16'd3, 32'd0, 1'b0};
        vecs[4] = '{3'd3, 12'h000, 16'd3, 32'd0, 1'b0};
        vecs[5] = '{3'd6, 12'h010, 16'd5, 32'd0, 1'b1};
        vecs[6] = '{3'd7, 12'h000, 16'd0, 32'd0, 1'b1};
        vecs[7] = '{3'd1, 12'h040, 16'd0, 32'd0, 1'b0};
        vecs[8] = '{3'd4, 12'h040, 16'd0, 32'd0, 1'b0};
        vecs[9] = '{3'd5, 12'h300, 16'd2, 32'd0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_core_state", {29'd0, core_state}, 32'd0);
        chk("rst_core_A", {20'd0, core_A}, 32'd0);
        chk("rst_core_D", core_D, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // LOAD_WM with a one-cycle gap after the first word
        push_core(3'd2, 12'h080, 32'h11, 1'b0);
        push_core(3'd2, 12'h081, 32'h22, 1'b0);
        push_core(3'd2, 12'h082, 32'h33, 1'b0);
        exp_done.push_back(1'b0);
        issue(3'd1, 12'h080, 16'd3);
        chk("wm_wr_ready", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_data = 32'h11;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wm_gap_state", {29'd0, core_state}, 32'd0);
        chk("wm_gap_A", {20'd0, core_A}, 32'h080);
        chk("wm_gap_D", core_D, 32'h11);
        wr_valid = 1'b1;
        wr_data = 32'h22;
        @(negedge clk);
        wr_data = 32'h33;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("wm_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("wm_done", {31'd0, done}, 32'd1);
        chk("wm_done_state", {29'd0, core_state}, 32'd0);
        @(negedge clk);

        // RUN len=5: exactly five consecutive PIP cycles, one done
        for (int i = 0; i < 5; i++) push_core(3'd6, 12'd0, 32'd0, 1'b0);
        exp_done.push_back(1'b0);
        issue(3'd3, 12'h000, 16'd5);
        npip = 0;
        run = 0;
        maxrun = 0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (core_state == 3'd6) begin
                npip++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (done) begin
                ndone++;
                chk("run_done_state", {29'd0, core_state}, 32'd0);
            end
            @(negedge clk);
        end
        chk("run_pip_count", npip, 5);
        chk("run_pip_consecutive", maxrun, 5);
        chk("run_done_count", ndone, 1);

        // Table of commands
        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        // Commands and write data presented while busy are ignored
        for (int i = 0; i < 10; i++) push_core(3'd6, 12'd0, 32'd0, 1'b0);
        exp_done.push_back(1'b0);
        issue(3'd3, 12'h000, 16'd10);
        repeat (3) @(negedge clk);
        chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("busy_busy", {31'd0, busy}, 32'd1);
        chk("busy_wr_ready", {31'd0, wr_ready}, 32'd0);
        cmd_valid = 1'b1;
        cmd_op = 3'd0;
        cmd_addr = 12'h005;
        cmd_len = 16'd1;
        wr_valid = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        wait_done();

        // Reset in the middle of a LOAD_AM aborts it
        push_core(3'd1, 12'h200, 32'h51, 1'b0);
        push_core(3'd1, 12'h201, 32'h52, 1'b0);
        push_core(3'd1, 12'h202, 32'h53, 1'b0);
        issue(3'd0, 12'h200, 16'd8);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data = 32'h51 + i;
            @(negedge clk);
        end
        wr_data = 32'h54;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_core_state", {29'd0, core_state}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        ncore = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (core_state != 3'd0) ncore++;
        end
        wr_valid = 1'b0;
        chk("abort_no_core", ncore, 0);

        repeat (4) @(negedge clk);
        chk("core_queue_left", exp_core.size(), 0);
        chk("rd_queue_left", exp_rd.size(), 0);
        chk("done_queue_left", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
